// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and constants for the serial byte receiver
//
// Purpose: receiver FSM state encoding, byte width, idle line level and the
//          half-bit helper used to centre sampling inside each serial bit.
// Ports:   none (package).

package serial_rx_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = 3;

  // Level of an idle serial line; also the reset value of the synchronizer.
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Offset from start-bit detection to the sampling point inside a bit.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
//
// Purpose: small synchronous FIFO shared by the rx and tx paths. A push
//          that arrives while full is accepted only when a pop happens in
//          the same cycle; otherwise it is ignored and the caller decides
//          what that means. Head data is read straight from storage, so it
//          is stable while nothing pops and never X after reset.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (empties FIFO, clears storage)
//   i_push   in   write i_data this cycle
//   i_data   in   WIDTH-bit write data
//   i_pop    in   remove the head entry this cycle (ignored when empty)
//   o_data   out  head entry
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_do_push;
  logic w_do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop && !o_empty;
  // When full, the popped slot is the one being written, so a simultaneous
  // push and pop is safe.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - serial line deframer feeding bytes into a FIFO
//
// Purpose: turns the 1-bit serial puzzle stream into bytes for the solver
//          core. Line: idle high, start bit 0, 8 data bits LSB first, stop
//          bit 1, each bit CLKS_PER_BIT clocks long.
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   data_in       in   raw serial line, asynchronous to clk
//   m_data        out  8-bit byte at FIFO head
//   m_valid       out  FIFO non-empty
//   m_ready       in   consumer takes m_data when m_valid && m_ready
//   frame_err     out  one-cycle pulse: stop bit sampled low
//   overflow      out  sticky: completed byte dropped because FIFO was full
//   overflow_clr  in   synchronous clear of overflow (a new overflow wins)

module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int HALF = half_bit(CLKS_PER_BIT);
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  // Only used when HALF > 0; kept non-negative so it elaborates for any HALF.
  localparam logic [CW-1:0] HALF_LOAD = CW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [BIT_IDX_W-1:0] BIT_ONE = BIT_IDX_W'(1);

  // Input synchronizer.
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  // Receiver state.
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BIT_IDX_W-1:0] r_bit;
  logic [BIT_IDX_W-1:0] w_bit_nxt;
  logic [BYTE_W-1:0]    r_shreg;
  logic [BYTE_W-1:0]    w_shreg_nxt;
  logic                 w_push_req;
  logic                 w_ferr_nxt;

  logic r_frame_err;
  logic r_overflow;

  // FIFO interface.
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_overflow_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= LINE_IDLE;
      r_sync2 <= LINE_IDLE;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_frame_err <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_push_req  = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rxs == 1'b0) begin
          w_bit_nxt = '0;
          // With no half-bit offset the start bit needs no mid-bit check;
          // the first data sample lands one full bit later.
          if (HALF == 0) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = BIT_LOAD;
          end else begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = HALF_LOAD;
          end
        end
      end

      ST_START: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (w_rxs == 1'b0) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = BIT_LOAD;
          w_bit_nxt   = '0;
        end else begin
          // Line went back high before mid-start: treat as a glitch.
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_shreg_nxt[r_bit] = w_rxs;
          w_cnt_nxt          = BIT_LOAD;
          if (r_bit == LAST_BIT) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_ONE;
          end
        end
      end

      ST_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (w_rxs == 1'b1) begin
          w_push_req  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = ST_BREAK;
        end
      end

      ST_BREAK: begin
        // A line held low after a bad stop bit must not look like a new start.
        if (w_rxs == 1'b1) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_pop          = !w_empty && m_ready;
  // A full FIFO still accepts the byte if the consumer frees a slot this cycle.
  assign w_overflow_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_overflow_set) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_data  (r_shreg_or_last()),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The stop sample and the last data bit live in different cycles, so the
  // shift register already holds the complete byte when the push fires.
  function automatic logic [BYTE_W-1:0] r_shreg_or_last();
    return r_shreg;
  endfunction

  assign m_valid   = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb/tb_serial_byte_rx.sv - directed self-checking bench for serial_byte_rx

module tb_serial_byte_rx;

  logic       clk;
  logic       rst_n;
  logic       din1, din4;
  logic       rdy1, rdy4;
  logic       clr1, clr4;
  logic [7:0] d1, d4;
  logic       v1, v4;
  logic       fe1, fe4;
  logic       ov1, ov4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] q1[$];
  logic [7:0] q4[$];
  int         fe1_cnt = 0;
  int         fe4_cnt = 0;

  serial_byte_rx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u_rx1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (din1),
    .m_data       (d1),
    .m_valid      (v1),
    .m_ready      (rdy1),
    .frame_err    (fe1),
    .overflow     (ov1),
    .overflow_clr (clr1)
  );

  serial_byte_rx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_rx4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (din4),
    .m_data       (d4),
    .m_valid      (v4),
    .m_ready      (rdy4),
    .frame_err    (fe4),
    .overflow     (ov4),
    .overflow_clr (clr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && v1 && rdy1) q1.push_back(d1);
    if (rst_n && v4 && rdy4) q4.push_back(d4);
    if (fe1) fe1_cnt <= fe1_cnt + 1;
    if (fe4) fe4_cnt <= fe4_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input bit sel4, input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel4) din4 = bits[i];
      else      din1 = bits[i];
      repeat (sel4 ? 4 : 1) tick();
    end
  endtask

  task automatic drain1(input int budget);
    int k;
    k = 0;
    while (v1 && k < budget) begin
      tick();
      k++;
    end
    chk("drain1_done", {31'd0, v1}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp4 [5];
    exp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};

    rst_n = 1'b0;
    din1 = 1'b1; din4 = 1'b1;
    rdy1 = 1'b1; rdy4 = 1'b1;
    clr1 = 1'b0; clr4 = 1'b0;
    repeat (3) tick();
    chk("rst_valid1", {31'd0, v1}, 0);
    chk("rst_data1",  {24'd0, d1}, 0);
    chk("rst_ferr1",  {31'd0, fe1}, 0);
    chk("rst_ovf1",   {31'd0, ov1}, 0);
    chk("rst_valid4", {31'd0, v4}, 0);
    chk("rst_data4",  {24'd0, d4}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 0x41 at one clock per bit: m_valid rises 3 clocks after the stop bit.
    send_frame(1'b0, 8'h41, 1'b1);
    chk("t1_valid_e10", {31'd0, v1}, 0);
    tick();
    chk("t1_valid_e11", {31'd0, v1}, 0);
    tick();
    chk("t1_valid_e12", {31'd0, v1}, 1);
    chk("t1_data",      {24'd0, d1}, 32'h41);
    tick();
    chk("t1_valid_e13", {31'd0, v1}, 0);
    chk("t1_count",     q1.size(), 1);
    chk("t1_ferr",      fe1_cnt, 0);

    // Back-to-back frames at four clocks per bit.
    q4.delete();
    send_frame(1'b1, 8'hA5, 1'b1);
    send_frame(1'b1, 8'h3C, 1'b1);
    repeat (8) tick();
    chk("t2_count", q4.size(), 2);
    chk("t2_byte0", {24'd0, q4[0]}, 32'hA5);
    chk("t2_byte1", {24'd0, q4[1]}, 32'h3C);
    chk("t2_ferr",  fe4_cnt, 0);

    // Bad stop bit followed by a stuck-low line.
    q1.delete();
    send_frame(1'b0, 8'h55, 1'b0);
    repeat (20) tick();
    chk("t3_ferr_once", fe1_cnt, 1);
    chk("t3_no_push",   q1.size(), 0);
    din1 = 1'b1;
    repeat (4) tick();
    send_frame(1'b0, 8'h5A, 1'b1);
    repeat (5) tick();
    chk("t3_recover_count", q1.size(), 1);
    chk("t3_recover_byte",  {24'd0, q1[0]}, 32'h5A);
    chk("t3_ferr_after",    fe1_cnt, 1);

    // Fill, overflow, set-beats-clear, clear, push+pop while full, drain.
    q1.delete();
    rdy1 = 1'b0;
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b0, 8'h02, 1'b1);
    send_frame(1'b0, 8'h03, 1'b1);
    send_frame(1'b0, 8'h04, 1'b1);
    repeat (3) tick();
    chk("t4_full_valid", {31'd0, v1}, 1);
    chk("t4_head_hold",  {24'd0, d1}, 32'h01);
    chk("t4_no_ovf_yet", {31'd0, ov1}, 0);
    send_frame(1'b0, 8'h05, 1'b1);
    tick();
    chk("t4_ovf_before_push", {31'd0, ov1}, 0);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("t4_set_wins",  {31'd0, ov1}, 1);
    chk("t4_head_same", {24'd0, d1}, 32'h01);
    tick();
    chk("t4_sticky", {31'd0, ov1}, 1);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("t4_cleared", {31'd0, ov1}, 0);
    send_frame(1'b0, 8'h06, 1'b1);
    tick();
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    chk("t4_pushpop_full_no_ovf", {31'd0, ov1}, 0);
    chk("t4_head_advanced",       {24'd0, d1}, 32'h02);
    rdy1 = 1'b1;
    drain1(20);
    chk("t4_drain_count", q1.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t4_drain_byte", {24'd0, q1[i]}, {24'd0, exp4[i]});
    end

    // One-clock low glitch on an idle line.
    q4.delete();
    din4 = 1'b0;
    tick();
    din4 = 1'b1;
    repeat (60) tick();
    chk("t5_no_byte", q4.size(), 0);
    chk("t5_no_ferr", fe4_cnt, 0);

    // Reset in the middle of data bit 3, then a clean frame.
    q4.delete();
    din4 = 1'b0;
    repeat (4) tick();
    din4 = 1'b1;
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid4", {31'd0, v4}, 0);
    chk("t6_rst_data1",  {24'd0, d1}, 0);
    chk("t6_rst_ferr4",  {31'd0, fe4}, 0);
    chk("t6_rst_ovf4",   {31'd0, ov4}, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(1'b1, 8'h7E, 1'b1);
    repeat (8) tick();
    chk("t6_count", q4.size(), 1);
    chk("t6_byte",  {24'd0, q4[0]}, 32'h7E);
    chk("t6_ferr",  fe4_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
